cayde_mdu: RTL and testbench
============================

# cayde_mdu

Parametrised multi-cycle multiply/divide unit for the cayde RISC-V core, implementing the eight RV32M/RV64M operations alongside the single-cycle integer ALU. It accepts one operation at a time through a valid/ready handshake and iterates one bit per cycle using a shift-add multiplier and a restoring divider that share one datapath. It holds the result until downstream accepts it and supports pipeline kill from the execute stage.

## Interface
- XLEN, 32: operand/result width; legal values 32 and 64.
- CNT_W, $clog2(XLEN): iteration counter width; derived, not overridden.

- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; 1 only in IDLE.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 operand (dividend / multiplicand).
- op_b  in  XLEN  rs2 operand (divisor / multiplier).
- kill_i  in  1  abort current operation (branch flush).
- valid_o  out  1  result valid; 1 only in DONE.
- ready_i  in  1  downstream accepts result.
- res_o  out  XLEN  result; stable while valid_o=1.
- busy_o  out  1  1 in CALC or DONE (hazard stall for decode).

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE; ready_o=1, valid_o=0, busy_o=0, res_o=0, counter=0, all internal registers 0.
- Accept: valid_i && ready_o at a rising edge latches op_i, operands, sign flags.
- Sign handling: signed operands converted to magnitude at accept; MULH both signed, MULHSU only op_a signed, MULHU/DIVU/REMU none. Result negated when leaving CALC if sign flag set: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Multiply: 2*XLEN accumulator; each CALC cycle adds multiplicand if multiplier LSB=1, then shifts right. MUL returns low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of the signed-corrected 2*XLEN product.
- Divide: restoring; each CALC cycle shifts {rem,quot} left, subtracts divisor, keeps difference if non-negative and sets quotient bit.
- Special cases bypass CALC (IDLE -> DONE directly, result loaded at accept edge):
  - divisor 0: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - DIV/REM with op_a = most negative and op_b = -1: DIV -> op_a; REM -> 0.
- Transitions: IDLE -> CALC on accept (normal); IDLE -> DONE on accept (special case); CALC -> DONE after XLEN iterations; DONE -> IDLE when ready_i=1.
- kill_i=1: from CALC or DONE go to IDLE next edge, valid_o drops, result discarded. kill_i in IDLE is ignored; kill_i has priority over valid_i in the same cycle (request not accepted).
- valid_i while busy: ignored (ready_o=0); the requester holds it.

## Timing
- Accept edge T: normal op enters CALC, counter=XLEN-1. Iterations on edges T+1..T+XLEN; enters DONE at edge T+XLEN. valid_o high from cycle after T+XLEN. Latency XLEN cycles (32 for XLEN=32).
- Special case: valid_o high in the cycle after accept edge (latency 1).
- DONE with ready_i=1: leaves on that edge, ready_o=1 next cycle. Back-to-back issue gap is therefore at least one idle cycle.
- ready_i=0: res_o and valid_o held indefinitely without change.
- ready_o, valid_o, busy_o decode registered state only (no input-to-output combinational path). res_o is a register.
- rst_i asserted mid-CALC/DONE: immediate return to reset values, no result produced.

## Test plan
- MUL 7 x 0xFFFFFFFD (-3) -> res_o 0xFFFFFFEB, valid_o exactly 32 cycles after accept; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both valid_o 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Backpressure: hold ready_i=0 for 5 cycles in DONE -> res_o/valid_o unchanged, ready_o=0, valid_i pulses ignored; ready_i=1 -> IDLE next edge.
- kill_i at CALC iteration 10, and kill_i coincident with valid_i in IDLE -> return to IDLE, valid_o never rises, no request accepted; next request computes correctly.
- rst_i pulse mid-CALC (asynchronous, between edges) -> outputs at reset values immediately; XLEN=64 regression: MULHU 0xFFFF..FF squared -> 0xFFFFFFFFFFFFFFFE, latency 64.

Source files
------------

// File: rtl/cayde_mdu.sv
// cayde_mdu: iterative RV32M/RV64M multiply/divide unit.
// Shift-add multiplier and restoring divider share one accumulator.
module cayde_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    localparam int W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic             neg_q;
    logic [W2-1:0]    acc;
    logic [XLEN-1:0]  dvs;
    logic [CNT_W-1:0] cnt;

    logic            accept;
    logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] special_res;

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign busy_o  = (state != IDLE);
    assign accept  = valid_i && (state == IDLE) && !kill_i;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        if (op_i[2]) begin
            a_sgn = !op_i[0];
            b_sgn = !op_i[0];
        end else begin
            a_sgn = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
            b_sgn = (op_i[1:0] == 2'b01);
        end
    end

    assign a_neg  = a_sgn && op_a[XLEN-1];
    assign b_neg  = b_sgn && op_b[XLEN-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b : op_b;
    // Remainder takes the dividend's sign; everything else the XOR.
    assign neg_in = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = op_i[2] && (op_b == '0);
    assign ovf      = op_i[2] && !op_i[0] && (op_a == MIN_NEG) && (op_b == '1);
    assign special  = div_zero || ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) special_res = op_i[1] ? op_a : '1;
        else          special_res = op_i[1] ? '0 : op_a;
    end

    logic [XLEN:0]   sum;
    logic [XLEN+1:0] diff;
    logic [W2-1:0]   mul_next, div_next, acc_next, prod;
    logic [XLEN-1:0] quo, rmd, res_calc;
    logic            unused_diff;

    assign sum      = {1'b0, acc[W2-1:XLEN]} + {1'b0, dvs};
    assign mul_next = acc[0] ? {sum, acc[XLEN-1:1]}
                             : {1'b0, acc[W2-1:XLEN], acc[XLEN-1:1]};
    assign diff     = {1'b0, acc[W2-1:XLEN-1]} - {2'b0, dvs};
    assign div_next = diff[XLEN+1] ? {acc[W2-2:0], 1'b0}
                                   : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign unused_diff = diff[XLEN];
    assign acc_next = op_q[2] ? div_next : mul_next;

    assign prod = neg_q ? -acc_next : acc_next;
    assign quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign rmd  = neg_q ? -acc_next[W2-1:XLEN] : acc_next[W2-1:XLEN];

    always_comb begin
        res_calc = '0;
        case (op_q)
            3'b000:                 res_calc = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_calc = prod[W2-1:XLEN];
            3'b100, 3'b101:         res_calc = quo;
            default:                res_calc = rmd;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            op_q  <= '0;
            neg_q <= 1'b0;
            acc   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            res_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_i;
                        neg_q <= neg_in;
                        dvs   <= op_i[2] ? b_mag : a_mag;
                        acc   <= {{XLEN{1'b0}}, op_i[2] ? a_mag : b_mag};
                        if (special) begin
                            res_o <= special_res;
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_LAST;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            res_o <= res_calc;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (kill_i) begin
                        res_o <= '0;
                        state <= IDLE;
                    end else if (ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cayde_mdu.sv
// tb_cayde_mdu: directed checks of the cayde_mdu multiply/divide unit.
// A 64-bit instance covers the wide-operand latency and product.
module tb_cayde_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] res_o;
    logic        busy_o;

    logic        v64 = 1'b0;
    logic        rdy64_o;
    logic [2:0]  op64 = '0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        vo64;
    logic        rdy64_i = 1'b0;
    logic [63:0] res64;
    logic        busy64;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cayde_mdu #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .op_a(op_a), .op_b(op_b), .kill_i(kill_i),
        .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .busy_o(busy_o)
    );

    cayde_mdu #(.XLEN(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(v64), .ready_o(rdy64_o),
        .op_i(op64), .op_a(a64), .op_b(b64), .kill_i(1'b0),
        .valid_o(vo64), .ready_i(rdy64_i), .res_o(res64), .busy_o(busy64)
    );

    // Issue one request, wait for the result and drain it.
    // edges = rising edges after the accept edge until valid_o is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int edges);
        valid_i = 1'b1; op_i = op; op_a = a; op_b = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        edges = 0;
        while (valid_o !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        res = res_o;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_o);
        else passed++;
        checks++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o);
        else passed++;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o);
        else passed++;
        checks++;
        if (res_o !== 32'h0) $display("FAIL reset_res got %h want 0", res_o);
        else passed++;
        checks++;
        if (res64 !== 64'h0 || rdy64_o !== 1'b1)
            $display("FAIL reset_64 got res %h rdy %b want 0/1", res64, rdy64_o);
        else passed++;
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int e;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, e);
        checks++;
        if (r !== 32'hFFFFFFEB) $display("FAIL mul got %h want ffffffeb", r);
        else passed++;
        checks++;
        if (e !== 32) $display("FAIL mul_latency got %0d want 32", e);
        else passed++;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, e);
        checks++;
        if (r !== 32'hFFFFFFFE) $display("FAIL mulhu got %h want fffffffe", r);
        else passed++;
        run_op(3'b001, 32'h80000000, 32'h80000000, r, e);
        checks++;
        if (r !== 32'h40000000) $display("FAIL mulh got %h want 40000000", r);
        else passed++;
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, r, e);
        checks++;
        if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu got %h want ffffffff", r);
        else passed++;
    endtask

    task automatic test_div();
        logic [31:0] r;
        int e;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, e);
        checks++;
        if (r !== 32'hFFFFFFFD) $display("FAIL div got %h want fffffffd", r);
        else passed++;
        checks++;
        if (e !== 32) $display("FAIL div_latency got %0d want 32", e);
        else passed++;
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, e);
        checks++;
        if (r !== 32'hFFFFFFFF) $display("FAIL rem got %h want ffffffff", r);
        else passed++;
        run_op(3'b101, 32'd100, 32'd7, r, e);
        checks++;
        if (r !== 32'd14) $display("FAIL divu got %h want e", r);
        else passed++;
        run_op(3'b111, 32'd100, 32'd7, r, e);
        checks++;
        if (r !== 32'd2) $display("FAIL remu got %h want 2", r);
        else passed++;
    endtask

    task automatic test_special();
        logic [31:0] r;
        int e;
        run_op(3'b101, 32'd5, 32'd0, r, e);
        checks++;
        if (r !== 32'hFFFFFFFF) $display("FAIL divu_zero got %h want ffffffff", r);
        else passed++;
        checks++;
        if (e !== 0) $display("FAIL divu_zero_latency got %0d want 0", e);
        else passed++;
        run_op(3'b110, 32'd5, 32'd0, r, e);
        checks++;
        if (r !== 32'd5) $display("FAIL rem_zero got %h want 5", r);
        else passed++;
        checks++;
        if (e !== 0) $display("FAIL rem_zero_latency got %0d want 0", e);
        else passed++;
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, e);
        checks++;
        if (r !== 32'h80000000) $display("FAIL div_ovf got %h want 80000000", r);
        else passed++;
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, e);
        checks++;
        if (r !== 32'h0) $display("FAIL rem_ovf got %h want 0", r);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        valid_i = 1'b1; op_i = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n = 0;
        while (valid_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (valid_o !== 1'b1) $display("FAIL bp_wait got valid %b want 1", valid_o);
        else passed++;
        op_i = 3'b000; op_a = 32'd2; op_b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            valid_i = (i % 2 == 0);
            @(posedge clk); #1;
            checks++;
            if (valid_o !== 1'b1 || res_o !== 32'd14 || ready_o !== 1'b0)
                $display("FAIL bp_hold got v %b res %h rdy %b want 1/e/0",
                         valid_o, res_o, ready_o);
            else passed++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL bp_release got rdy %b v %b want 1/0", ready_o, valid_o);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL bp_no_accept got busy %b want 0", busy_o);
        else passed++;
    endtask

    task automatic test_kill();
        logic [31:0] r;
        int e;
        logic saw;
        valid_i = 1'b1; op_i = 3'b000; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL kill_calc got v %b rdy %b busy %b want 0/1/0",
                     valid_o, ready_o, busy_o);
        else passed++;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) $display("FAIL kill_no_result got %b want 0", saw);
        else passed++;
        valid_i = 1'b1; kill_i = 1'b1; op_i = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL kill_idle got busy %b rdy %b want 0/1", busy_o, ready_o);
        else passed++;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, e);
        checks++;
        if (r !== 32'hFFFFFFFE) $display("FAIL kill_next got %h want fffffffe", r);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int e;
        valid_i = 1'b1; op_i = 3'b000; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL rst_mid_ctl got busy %b v %b rdy %b want 0/0/1",
                     busy_o, valid_o, ready_o);
        else passed++;
        checks++;
        if (res_o !== 32'h0) $display("FAIL rst_mid_res got %h want 0", res_o);
        else passed++;
        #10;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(3'b000, 32'd6, 32'd7, r, e);
        checks++;
        if (r !== 32'd42) $display("FAIL rst_mid_next got %h want 2a", r);
        else passed++;
    endtask

    task automatic test_xlen64();
        int n;
        v64 = 1'b1; op64 = 3'b011; a64 = '1; b64 = '1;
        @(posedge clk); #1;
        v64 = 1'b0;
        n = 0;
        while (vo64 !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (res64 !== 64'hFFFFFFFFFFFFFFFE)
            $display("FAIL mulhu64 got %h want fffffffffffffffe", res64);
        else passed++;
        checks++;
        if (n !== 64) $display("FAIL mulhu64_latency got %0d want 64", n);
        else passed++;
        rdy64_i = 1'b1;
        @(posedge clk); #1;
        rdy64_i = 1'b0;
        checks++;
        if (rdy64_o !== 1'b1 || busy64 !== 1'b0)
            $display("FAIL mulhu64_release got rdy %b busy %b want 1/0", rdy64_o, busy64);
        else passed++;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_xlen64();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
